alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 4, execute cycles of mul (alu_select 6'b001010); legal range 2..15.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15, maximum MEM-state cycles waiting for mem_ready; legal range 1..255.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  IR2 stage holds a decoded instruction.
REQ-006 SHALL have port alu_select  input  6  decoded ALU select code, valid with in_valid.
REQ-007 SHALL have port branch_taken  input  1  ALU compare result; sampled only in EXEC for codes 6'b011100..6'b100001.
REQ-008 SHALL have port mem_ready  input  1  data memory completes the current request.
REQ-009 SHALL have port in_ready  output  1  sequencer accepts the instruction this cycle (transfer = in_valid & in_ready).
REQ-010 SHALL have port op_q  output  6  registered alu_select of the instruction in flight.
REQ-011 SHALL have port alu_en  output  1  ALU computes op_q this cycle.
REQ-012 SHALL have port mem_req  output  1  memory request for lw/sw in flight.
REQ-013 SHALL have port wb_en  output  1  one-cycle register-file writeback strobe.
REQ-014 SHALL have port flush  output  1  one-cycle front-end flush strobe.
REQ-015 SHALL have port err  output  1  one-cycle strobe: illegal code or memory timeout.

Function
REQ-016 SHALL implement states IDLE, EXEC, MUL, MEM; in_ready=1 in IDLE; in_valid with in_ready=0 SHALL be ignored (upstream holds).
REQ-017 SHALL, on transfer, load op_q and enter EXEC next cycle; alu_en=1 in every EXEC and MUL cycle, 0 elsewhere.
REQ-018 SHALL, in EXEC for single-cycle codes 0..9 and 11..22, assert wb_en and in_ready; transfer stays in EXEC (one instruction per cycle), else IDLE.
REQ-019 SHALL, in EXEC for mul, load cycle counter with MUL_CYCLES-2 and enter MUL; MUL decrements counter, and at counter 0 asserts wb_en and in_ready, next state EXEC on transfer else IDLE; mul latency from EXEC to wb_en = MUL_CYCLES cycles.
REQ-020 SHALL, in EXEC for lw (6'b010111) or sw (6'b011000), enter MEM with mem_req=1 held every MEM cycle until mem_ready.
REQ-021 SHALL, in MEM on mem_ready, drop mem_req next cycle, assert wb_en for lw only, in_ready=1, next EXEC on transfer else IDLE.
REQ-022 SHALL count MEM cycles in an 8-bit counter; after MEM_TIMEOUT cycles without mem_ready, pulse err, drop mem_req, no wb_en, return IDLE; mem_ready in the timeout cycle SHALL win (normal completion).
REQ-023 SHALL, in EXEC for jr/jalr/jal (6'b011001..6'b011011), pulse flush, wb_en for jalr/jal only, in_ready=0, next IDLE.
REQ-024 SHALL, in EXEC for branches (6'b011100..6'b100001), pulse flush with in_ready=0 if branch_taken, else in_ready=1 without flush; never wb_en.
REQ-025 SHALL treat codes 6'b100010..6'b111111 as NOP: err pulse in EXEC, no wb_en, in_ready=1.
REQ-026 SHALL keep wb_en, flush, err combinational from state/op_q/counters, never asserted outside the cycles above.

Reset
REQ-027 SHALL, on rst_n low at any time including mid-MUL or mid-MEM, force IDLE, op_q=0, counters=0, mem_req=0; alu_en, wb_en, flush, err=0; in_ready=0 while rst_n low, 1 from first cycle after release.
REQ-028 SHALL discard an in-flight instruction on reset without wb_en or err.

Structure
REQ-029 SHALL place alu_select code constants, state enum and op-class enum (ALU1, MUL, LOAD, STORE, JUMP_LINK, JUMP, BRANCH, ILLEGAL) in shared package alu_pkg.
REQ-030 SHALL use one combinational sub-module op_classifier mapping op_q to op class.

Verification
REQ-031 Back-to-back add, xor, addi transfers -> EXEC three consecutive cycles, wb_en=1 each cycle, in_ready stays 1.
REQ-032 mul, MUL_CYCLES=4 -> alu_en 4 cycles, wb_en in 4th only, in_ready=0 for first 3; following add accepted in 4th cycle.
REQ-033 lw, mem_ready after 3 MEM cycles -> mem_req high 3 cycles, wb_en in 3rd; sw same with wb_en=0.
REQ-034 lw, mem_ready never, MEM_TIMEOUT=15 -> err at 15th MEM cycle, mem_req low next, IDLE, no wb_en.
REQ-035 beq branch_taken=1 -> flush 1 cycle, in_ready=0, no wb_en; jal -> flush and wb_en; code 6'b111111 -> err only.
REQ-036 rst_n low in 2nd MUL cycle -> all outputs 0 immediately, IDLE after release, no wb_en for the aborted mul.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU select codes, sequencer state encoding and instruction classes
// for the IR2-stage ALU sequencer.
package alu_pkg;

  localparam logic [5:0] ALU_ADD       = 6'b000000;
  localparam logic [5:0] ALU_XOR       = 6'b000100;
  localparam logic [5:0] ALU_MUL       = 6'b001010;
  localparam logic [5:0] ALU_ADDI      = 6'b001011;
  localparam logic [5:0] ALU_LW        = 6'b010111;
  localparam logic [5:0] ALU_SW        = 6'b011000;
  localparam logic [5:0] ALU_JR        = 6'b011001;
  localparam logic [5:0] ALU_JALR      = 6'b011010;
  localparam logic [5:0] ALU_JAL       = 6'b011011;
  localparam logic [5:0] ALU_BEQ       = 6'b011100;
  localparam logic [5:0] ALU_BR_LAST   = 6'b100001;
  localparam logic [5:0] ALU_NOP_FIRST = 6'b100010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MUL,
    ST_MEM
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU1,
    CLS_MUL,
    CLS_LOAD,
    CLS_STORE,
    CLS_JUMP_LINK,
    CLS_JUMP,
    CLS_BRANCH,
    CLS_ILLEGAL
  } op_class_t;

endpackage

// File: rtl/op_classifier.sv
// Combinational decode of a registered ALU select code into its execution class.
module op_classifier
  import alu_pkg::*;
(
  input  logic [5:0] op,
  output op_class_t  op_class
);

  always_comb begin
    op_class = CLS_ALU1;
    if (op == ALU_MUL)                              op_class = CLS_MUL;
    else if (op == ALU_LW)                          op_class = CLS_LOAD;
    else if (op == ALU_SW)                          op_class = CLS_STORE;
    else if (op == ALU_JR)                          op_class = CLS_JUMP;
    else if (op == ALU_JALR || op == ALU_JAL)       op_class = CLS_JUMP_LINK;
    else if (op >= ALU_BEQ && op <= ALU_BR_LAST)    op_class = CLS_BRANCH;
    else if (op >= ALU_NOP_FIRST)                   op_class = CLS_ILLEGAL;
  end

endmodule

// File: rtl/alu_sequencer.sv
// Issue/execute sequencer: accepts one decoded instruction at a time and
// drives ALU enable, memory request and writeback/flush/error strobes.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES  = 4,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [5:0] alu_select,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       in_ready,
  output logic [5:0] op_q,
  output logic       alu_en,
  output logic       mem_req,
  output logic       wb_en,
  output logic       flush,
  output logic       err
);

  state_t    state;
  op_class_t op_class;
  logic [3:0] mul_cnt;
  logic [7:0] mem_cnt;
  logic       ready;
  logic       mem_timeout;
  logic       transfer;

  op_classifier u_op_classifier (
    .op       (op_q),
    .op_class (op_class)
  );

  // mem_cnt is zero in the first MEM cycle, so the last allowed cycle is MEM_TIMEOUT-1
  assign mem_timeout = (mem_cnt == 8'(MEM_TIMEOUT - 1));
  assign alu_en      = (state == ST_EXEC) || (state == ST_MUL);
  assign mem_req     = (state == ST_MEM);
  assign in_ready    = ready & rst_n;
  assign transfer    = in_valid & in_ready;

  always_comb begin
    ready = 1'b0;
    wb_en = 1'b0;
    flush = 1'b0;
    err   = 1'b0;
    case (state)
      ST_IDLE: ready = 1'b1;
      ST_EXEC: begin
        case (op_class)
          CLS_ALU1: begin
            wb_en = 1'b1;
            ready = 1'b1;
          end
          CLS_JUMP_LINK: begin
            flush = 1'b1;
            wb_en = 1'b1;
          end
          CLS_JUMP:   flush = 1'b1;
          CLS_BRANCH: begin
            flush = branch_taken;
            ready = ~branch_taken;
          end
          CLS_ILLEGAL: begin
            err   = 1'b1;
            ready = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MUL: begin
        if (mul_cnt == '0) begin
          wb_en = 1'b1;
          ready = 1'b1;
        end
      end
      ST_MEM: begin
        if (mem_ready) begin
          ready = 1'b1;
          wb_en = (op_class == CLS_LOAD);
        end else if (mem_timeout) begin
          err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      op_q    <= '0;
      mul_cnt <= '0;
      mem_cnt <= '0;
    end else if (transfer) begin
      state <= ST_EXEC;
      op_q  <= alu_select;
    end else begin
      case (state)
        ST_EXEC: begin
          case (op_class)
            CLS_MUL: begin
              mul_cnt <= 4'(MUL_CYCLES - 2);
              state   <= ST_MUL;
            end
            CLS_LOAD, CLS_STORE: begin
              mem_cnt <= '0;
              state   <= ST_MEM;
            end
            default: state <= ST_IDLE;
          endcase
        end
        ST_MUL: begin
          if (mul_cnt == '0) state <= ST_IDLE;
          else               mul_cnt <= mul_cnt - 4'd1;
        end
        ST_MEM: begin
          if (mem_ready || mem_timeout) state <= ST_IDLE;
          else                          mem_cnt <= mem_cnt + 8'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic compared each
// cycle against an instruction-age reference model.
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int MC = 4;
  localparam int MT = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [5:0] alu_select = '0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       in_ready;
  logic [5:0] op_q;
  logic       alu_en, mem_req, wb_en, flush, err;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: whether an instruction is in flight, its code and its
  // age in cycles since it entered execution.
  bit busy    = 1'b0;
  int m_op    = 0;
  int age     = 0;
  int last_op = 0;

  alu_sequencer #(
    .MUL_CYCLES  (MC),
    .MEM_TIMEOUT (MT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .alu_select   (alu_select),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .in_ready     (in_ready),
    .op_q         (op_q),
    .alu_en       (alu_en),
    .mem_req      (mem_req),
    .wb_en        (wb_en),
    .flush        (flush),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic step(input logic v, input logic [5:0] sel, input logic tk,
                      input logic mr, input logic rn);
    int e_rdy, e_alu, e_mem, e_wb, e_fl, e_err;
    bit done;
    @(negedge clk);
    rst_n        = rn;
    in_valid     = v;
    alu_select   = sel;
    branch_taken = tk;
    mem_ready    = mr;
    #1;
    e_rdy = 0; e_alu = 0; e_mem = 0; e_wb = 0; e_fl = 0; e_err = 0;
    done  = 1'b0;
    if (!rn) begin
      busy    = 1'b0;
      last_op = 0;
    end else if (!busy) begin
      e_rdy = 1;
    end else if (m_op == 10) begin
      e_alu = 1;
      if (age == MC - 1) begin e_wb = 1; e_rdy = 1; done = 1'b1; end
    end else if (m_op == 23 || m_op == 24) begin
      if (age == 0) e_alu = 1;
      else begin
        e_mem = 1;
        if (mr) begin
          e_wb = (m_op == 23) ? 1 : 0; e_rdy = 1; done = 1'b1;
        end else if (age == MT) begin
          e_err = 1; done = 1'b1;
        end
      end
    end else if (m_op >= 25 && m_op <= 27) begin
      e_alu = 1; e_fl = 1; e_wb = (m_op != 25) ? 1 : 0; done = 1'b1;
    end else if (m_op >= 28 && m_op <= 33) begin
      e_alu = 1; e_fl = tk ? 1 : 0; e_rdy = tk ? 0 : 1; done = 1'b1;
    end else if (m_op >= 34) begin
      e_alu = 1; e_err = 1; e_rdy = 1; done = 1'b1;
    end else begin
      e_alu = 1; e_wb = 1; e_rdy = 1; done = 1'b1;
    end

    check("in_ready", in_ready, e_rdy);
    check("op_q",     op_q,     last_op);
    check("alu_en",   alu_en,   e_alu);
    check("mem_req",  mem_req,  e_mem);
    check("wb_en",    wb_en,    e_wb);
    check("flush",    flush,    e_fl);
    check("err",      err,      e_err);

    if (rn) begin
      if (e_rdy == 1 && v) begin
        busy = 1'b1; m_op = int'(sel); last_op = int'(sel); age = 0;
      end else if (done) begin
        busy = 1'b0;
      end else if (busy) begin
        age++;
      end
    end
  endtask

  initial begin
    logic [5:0] sel;
    step(0, '0, 0, 0, 0);
    step(0, '0, 0, 0, 0);
    // back-to-back single-cycle ops
    step(1, ALU_ADD, 0, 0, 1);
    step(1, ALU_XOR, 0, 0, 1);
    step(1, ALU_ADDI, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    // mul with a held follower
    step(1, ALU_MUL, 0, 0, 1);
    repeat (4) step(1, ALU_ADD, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    // lw and sw with mem_ready on the third MEM cycle
    step(1, ALU_LW, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 1, 1);
    step(0, '0, 0, 0, 1);
    step(1, ALU_SW, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 1, 1);
    step(0, '0, 0, 0, 1);
    // lw timeout
    step(1, ALU_LW, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    repeat (MT + 2) step(0, '0, 0, 0, 1);
    // control flow and illegal code
    step(1, ALU_BEQ, 0, 0, 1);
    step(1, ALU_ADD, 1, 0, 1);
    step(0, '0, 0, 0, 1);
    step(1, ALU_BEQ, 0, 0, 1);
    step(1, ALU_ADD, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    step(1, ALU_JAL, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    step(1, ALU_JR, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    step(1, 6'h3f, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    // reset during the second MUL cycle
    step(1, ALU_MUL, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 0);
    step(0, '0, 0, 0, 0);
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    // random traffic
    repeat (3000) begin
      case ($urandom_range(0, 5))
        0:       sel = 6'(ALU_MUL);
        1:       sel = 6'($urandom_range(23, 24));
        2:       sel = 6'($urandom_range(25, 33));
        3:       sel = 6'($urandom_range(34, 63));
        default: sel = 6'($urandom_range(0, 22));
      endcase
      step(1'($urandom_range(0, 1)), sel, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 199) != 0));
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
